// File: rtl/pio_edge_event_ctrl.sv
// pio_edge_event_ctrl: Avalon-MM master servicing an edge-capture PIO, queueing {capture,data} events.
// Optional EVT_TIMESTAMP_EN adds a 16-bit timestamp in evt_data[31:16].
module pio_edge_event_ctrl #(
  parameter logic [7:0] MASK_INIT = 8'hFF,
  parameter int FIFO_DEPTH = 8,
  parameter int OVF_W = 8,
`ifdef EVT_TIMESTAMP_EN
  localparam int EW = 32
`else
  localparam int EW = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic             cfg_mask_wr,
  input  logic [7:0]       cfg_mask,
  output logic             evt_valid,
  output logic [EW-1:0]    evt_data,
  input  logic             evt_ready,
  output logic [OVF_W-1:0] ovf_count,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {INIT_MASK, INIT_CLR, IDLE, SET_MASK, RD_CAP, RD_DAT, LATCH, CLR, PUSH} state_t;
  state_t state, state_n;
  logic active, mask_pend, wr, rd, push_req, push, pop, full;
  logic [7:0] mask_lat, cap, dat;
  logic [AW:0] wp, rp;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] push_word;
  logic unused_rd;
  assign unused_rd = ^pio_readdata[31:8];
  // active holds the bus idle for the first cycle after reset so the init writes follow release
  always_comb begin
    state_n = state;
    if (active)
      case (state)
        INIT_MASK: state_n = INIT_CLR;
        INIT_CLR:  state_n = IDLE;
        IDLE:      state_n = mask_pend ? SET_MASK : pio_irq ? RD_CAP : IDLE;
        SET_MASK:  state_n = IDLE;
        RD_CAP:    state_n = RD_DAT;
        RD_DAT:    state_n = LATCH;
        LATCH:     state_n = CLR;
        CLR:       state_n = PUSH;
        default:   state_n = IDLE;
      endcase
  end
  assign wr = active && (state inside {INIT_MASK, INIT_CLR, SET_MASK, CLR});
  assign rd = active && (state inside {RD_CAP, RD_DAT});
  assign pio_chipselect = wr | rd;
  assign pio_write_n = !wr;
  assign pio_address = !(wr | rd) ? 2'd0 : (state == INIT_MASK || state == SET_MASK) ? 2'd2 :
                       state == RD_DAT ? 2'd0 : 2'd3;
  assign pio_writedata = !active ? 32'd0 : state == INIT_MASK ? {24'd0, MASK_INIT} :
                         state == SET_MASK ? {24'd0, mask_lat} : 32'd0;
  assign busy = state != IDLE;
  assign evt_valid = wp != rp;
  assign evt_data = mem[rp[AW-1:0]];
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = evt_valid && evt_ready;
  assign push_req = state == PUSH && cap != 8'd0;
  assign push = push_req && (!full || pop);
`ifdef EVT_TIMESTAMP_EN
  logic [15:0] ts, ts_lat;
  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= 16'd0;
      ts_lat <= 16'd0;
    end else begin
      ts <= ts + 16'd1;
      if (state == RD_CAP) ts_lat <= ts;
    end
  end
  assign push_word = {ts_lat, cap, dat};
`else
  assign push_word = {cap, dat};
`endif
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= push_word;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT_MASK;
      active <= 1'b0;
      mask_pend <= 1'b0;
      mask_lat <= 8'd0;
      cap <= 8'd0;
      dat <= 8'd0;
      wp <= '0;
      rp <= '0;
      ovf_count <= '0;
    end else begin
      state <= state_n;
      active <= 1'b1;
      if (cfg_mask_wr) begin
        mask_pend <= 1'b1;
        mask_lat <= cfg_mask;
      end else if (state == SET_MASK) mask_pend <= 1'b0;
      if (state == RD_DAT) cap <= pio_readdata[7:0];
      if (state == LATCH) dat <= pio_readdata[7:0];
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      if (push_req && !push && ovf_count != '1) ovf_count <= ovf_count + OVF_W'(1);
    end
  end
endmodule

// File: tb/tb_pio_edge_event_ctrl.sv
// tb_pio_edge_event_ctrl: directed bench with an edge-capture PIO model and bus-transaction log.
module tb_pio_edge_event_ctrl;
`ifdef EVT_TIMESTAMP_EN
  localparam int EW = 32;
`else
  localparam int EW = 16;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic [1:0] pio_address;
  logic pio_chipselect, pio_write_n, pio_irq, cfg_mask_wr = 1'b0, evt_valid, evt_ready = 1'b0, busy;
  logic [31:0] pio_writedata, rdata = 32'd0;
  logic [7:0] cfg_mask = 8'd0, ovf_count;
  logic [EW-1:0] evt_data;
  logic [7:0] m_cap = 8'd0, m_mask = 8'd0, dat_in = 8'd0, inj_val = 8'd0;
  logic inj = 1'b0, irq_force = 1'b0;
  logic [10:0] log_q[$];
  int n_chk = 0, n_fail = 0;

  pio_edge_event_ctrl dut (
    .clk(clk), .reset(reset), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .pio_readdata(rdata),
    .pio_irq(pio_irq), .cfg_mask_wr(cfg_mask_wr), .cfg_mask(cfg_mask), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_ready(evt_ready), .ovf_count(ovf_count), .busy(busy)
  );

  assign pio_irq = |(m_cap & m_mask) | irq_force;

  // PIO slave model: registered readdata, write to addr 3 clears captures (clear beats a new edge)
  always @(posedge clk) begin
    if (pio_chipselect) log_q.push_back({pio_write_n, pio_address, pio_writedata[7:0]});
    rdata <= !(pio_chipselect && pio_write_n) ? 32'd0 : pio_address == 2'd3 ? {24'd0, m_cap} :
             pio_address == 2'd2 ? {24'd0, m_mask} : pio_address == 2'd0 ? {24'd0, dat_in} : 32'd0;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) m_mask <= pio_writedata[7:0];
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) m_cap <= 8'd0;
    else if (inj) m_cap <= m_cap | inj_val;
  end

  // returns at the falling edge of the first cycle in which irq is high
  task automatic inject(input logic [7:0] v);
    @(negedge clk); inj = 1'b1; inj_val = v;
    @(negedge clk); inj = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      n_fail++; $display("FAIL rst_bus got cs=%0b wn=%0b a=%0d wd=%h want idle", pio_chipselect, pio_write_n, pio_address, pio_writedata); end
    n_chk++; if ({evt_valid, ovf_count} !== 9'd0) begin
      n_fail++; $display("FAIL rst_fifo got valid=%0b ovf=%0d want 0/0", evt_valid, ovf_count); end
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'hFF}) begin
      n_fail++; $display("FAIL init_mask got cs=%0b wn=%0b a=%0d wd=%h want write a2=ff", pio_chipselect, pio_write_n, pio_address, pio_writedata); end
    @(negedge clk);
    n_chk++; if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd3, 32'd0}) begin
      n_fail++; $display("FAIL init_clr got cs=%0b wn=%0b a=%0d wd=%h want write a3=0", pio_chipselect, pio_write_n, pio_address, pio_writedata); end
    @(negedge clk);
    n_chk++; if ({busy, pio_chipselect} !== 2'b00) begin
      n_fail++; $display("FAIL init_idle got busy=%0b cs=%0b want 0/0", busy, pio_chipselect); end
  endtask

  task automatic test_single_event;
    dat_in = 8'h81;
    log_q.delete();
    inject(8'h05);
    n_chk++; if ({pio_irq, busy} !== 2'b10) begin
      n_fail++; $display("FAIL single_start got irq=%0b busy=%0b want 1/0", pio_irq, busy); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_early cycle %0d valid=%0b want 0", k, evt_valid); end
      end else begin
        n_chk++; if ({evt_valid, evt_data[15:0]} !== {1'b1, 16'h0581}) begin
          n_fail++; $display("FAIL single_evt got valid=%0b data=%h want 1/0581", evt_valid, evt_data[15:0]); end
      end
    end
    n_chk++; if (log_q.size() != 3 || log_q[0] !== {1'b1, 2'd3, 8'd0} || log_q[1] !== {1'b1, 2'd0, 8'd0} || log_q[2] !== {1'b0, 2'd3, 8'd0}) begin
      n_fail++; $display("FAIL single_bus got %0d ops want rd3,rd0,wr3", log_q.size()); end
    evt_ready = 1'b1;
    @(negedge clk); evt_ready = 1'b0;
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop valid=%0b want 0", evt_valid); end
  endtask

  task automatic test_overflow;
    logic [7:0] c, d;
    for (int i = 0; i < 9; i++) begin
      dat_in = 8'h10 + 8'(i);
      inject(8'(i + 1));
      repeat (8) @(negedge clk);
    end
    n_chk++; if (ovf_count !== 8'd1) begin n_fail++; $display("FAIL ovf_count got %0d want 1", ovf_count); end
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = 8'(i + 1); d = 8'h10 + 8'(i);
      n_chk++; if ({evt_valid, evt_data[15:0]} !== {1'b1, c, d}) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got valid=%0b data=%h want 1/%h%h", i, evt_valid, evt_data[15:0], c, d); end
      @(negedge clk);
    end
    evt_ready = 1'b0;
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty valid=%0b want 0", evt_valid); end
  endtask

  task automatic test_full_pop;
    logic [7:0] c, d;
    for (int i = 0; i < 8; i++) begin
      dat_in = 8'h30 + 8'(i);
      inject(8'h20 + 8'(i));
      repeat (8) @(negedge clk);
    end
    dat_in = 8'h55;
    inject(8'h77);
    repeat (5) @(negedge clk);
    evt_ready = 1'b1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fullpop_busy got %0b want 1", busy); end
    @(negedge clk); evt_ready = 1'b0;
    n_chk++; if (ovf_count !== 8'd1) begin n_fail++; $display("FAIL fullpop_ovf got %0d want 1", ovf_count); end
    evt_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      c = 8'h20 + 8'(i); d = 8'h30 + 8'(i);
      n_chk++; if ({evt_valid, evt_data[15:0]} !== {1'b1, c, d}) begin
        n_fail++; $display("FAIL fullpop_drain[%0d] got valid=%0b data=%h want 1/%h%h", i, evt_valid, evt_data[15:0], c, d); end
      @(negedge clk);
    end
    n_chk++; if ({evt_valid, evt_data[15:0]} !== {1'b1, 16'h7755}) begin
      n_fail++; $display("FAIL fullpop_last got valid=%0b data=%h want 1/7755", evt_valid, evt_data[15:0]); end
    @(negedge clk); evt_ready = 1'b0;
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty valid=%0b want 0", evt_valid); end
  endtask

  task automatic test_mask_update;
    logic [10:0] exp_ops [7];
    exp_ops = '{{1'b1, 2'd3, 8'd0}, {1'b1, 2'd0, 8'd0}, {1'b0, 2'd3, 8'd0}, {1'b0, 2'd2, 8'h3C},
                {1'b1, 2'd3, 8'd0}, {1'b1, 2'd0, 8'd0}, {1'b0, 2'd3, 8'd0}};
    dat_in = 8'h22;
    log_q.delete();
    inject(8'h01);
    @(negedge clk);
    @(negedge clk); cfg_mask_wr = 1'b1; cfg_mask = 8'h3C;
    @(negedge clk); cfg_mask_wr = 1'b0;
    @(negedge clk);
    @(negedge clk); inj = 1'b1; inj_val = 8'h04;
    @(negedge clk); inj = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++; if (log_q.size() != 7) begin n_fail++; $display("FAIL mask_opcount got %0d want 7", log_q.size()); end
    for (int i = 0; i < 7; i++) begin
      n_chk++; if (i >= log_q.size() || log_q[i] !== exp_ops[i]) begin
        n_fail++; $display("FAIL mask_op[%0d] got %h want %h", i, (i < log_q.size()) ? log_q[i] : 11'h7FF, exp_ops[i]); end
    end
    n_chk++; if (m_mask !== 8'h3C) begin n_fail++; $display("FAIL mask_applied got %h want 3c", m_mask); end
    evt_ready = 1'b1;
    n_chk++; if ({evt_valid, evt_data[15:0]} !== {1'b1, 16'h0122}) begin
      n_fail++; $display("FAIL mask_evt0 got valid=%0b data=%h want 1/0122", evt_valid, evt_data[15:0]); end
    @(negedge clk);
    n_chk++; if ({evt_valid, evt_data[15:0]} !== {1'b1, 16'h0422}) begin
      n_fail++; $display("FAIL mask_evt1 got valid=%0b data=%h want 1/0422", evt_valid, evt_data[15:0]); end
    @(negedge clk); evt_ready = 1'b0;
  endtask

  task automatic test_spurious;
    log_q.delete();
    @(negedge clk); irq_force = 1'b1;
    @(negedge clk); irq_force = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (log_q.size() != 3 || log_q[0] !== {1'b1, 2'd3, 8'd0} || log_q[1] !== {1'b1, 2'd0, 8'd0} || log_q[2] !== {1'b0, 2'd3, 8'd0}) begin
      n_fail++; $display("FAIL spur_bus got %0d ops want rd3,rd0,wr3", log_q.size()); end
    n_chk++; if ({evt_valid, ovf_count} !== {1'b0, 8'd1}) begin
      n_fail++; $display("FAIL spur_evt got valid=%0b ovf=%0d want 0/1", evt_valid, ovf_count); end
  endtask

  task automatic test_reset_mid;
    inject(8'h09);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_chk++; if ({pio_chipselect, busy} !== 2'b01) begin
      n_fail++; $display("FAIL midrst_bus got cs=%0b busy=%0b want 0/1", pio_chipselect, busy); end
    reset = 1'b0;
    log_q.delete();
    repeat (12) @(negedge clk);
    n_chk++; if (log_q.size() != 2 || log_q[0] !== {1'b0, 2'd2, 8'hFF} || log_q[1] !== {1'b0, 2'd3, 8'd0}) begin
      n_fail++; $display("FAIL midrst_init got %0d ops want wr2=ff,wr3", log_q.size()); end
    n_chk++; if ({evt_valid, ovf_count, busy} !== 10'd0) begin
      n_fail++; $display("FAIL midrst_state got valid=%0b ovf=%0d busy=%0b want 0/0/0", evt_valid, ovf_count, busy); end
  endtask

`ifdef EVT_TIMESTAMP_EN
  task automatic test_timestamp;
    logic [15:0] t0;
    dat_in = 8'h01;
    inject(8'h01);
    repeat (98) @(negedge clk);
    inject(8'h02);
    repeat (8) @(negedge clk);
    t0 = evt_data[31:16];
    evt_ready = 1'b1;
    @(negedge clk);
    n_chk++; if ({evt_valid, evt_data[15:0], evt_data[31:16]} !== {1'b1, 16'h0201, t0 + 16'd100}) begin
      n_fail++; $display("FAIL ts_delta got valid=%0b data=%h ts=%0d want ts=%0d", evt_valid, evt_data[15:0], evt_data[31:16], t0 + 16'd100); end
    @(negedge clk); evt_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single_event;
    test_overflow;
    test_full_pop;
    test_mask_update;
    test_spurious;
    test_reset_mid;
`ifdef EVT_TIMESTAMP_EN
    test_timestamp;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
